uart_mod_counter: RTL and testbench

Parametrised modulo-N counter with built-in prescaler, direction control, synchronous clear/load and terminal-count/wrap flags. It is the general-purpose successor to the fixed 3-bit counter. It serves as the bit-index, oversample-tick and baud-divider counter in the UART transmitter and receiver datapaths. One instance replaces each hand-written counter in the TX/RX state machines.

---
 rtl/uart_mod_counter.sv | 106 ++++++++++
 tb/tb_uart_mod_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mod_counter.sv
// uart_mod_counter: parametrised modulo-MODULUS counter with ena-qualified
// prescaler, up/down direction, synchronous clear/load (load clamped to
// MODULUS-1), combinational terminal-count flag and registered wrap pulse.
// Build option: define UART_CNT_SATURATE_EN to make the counter saturate at
// its terminal value instead of wrapping (wrap is then never asserted).
module uart_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 10,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

`ifdef UART_CNT_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    // One bit wider so MODULUS == 2**WIDTH is representable for the clamp.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             step;

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int unsigned   PW       = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_q, pre_d;

            // Prescaler next state: restart on clr/load, advance on ena.
            always_comb begin
                pre_d = pre_q;
                if (clr || load) begin
                    pre_d = '0;
                end else if (ena) begin
                    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
                end
            end

            // Prescaler register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_d;
                end
            end

            assign step = ena && (pre_q == PRE_LAST);
        end else begin : g_nopre
            assign step = ena;
        end
    endgenerate

    // Terminal value depends on the current direction, zero latency.
    assign tc = dir ? (count_q == '0) : (count_q == LAST);

    // Count next state: clr > load > step; wrap pulses only on a wrapping step.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = ({1'b0, load_val} >= MOD_EXT) ? LAST : load_val;
        end else if (step) begin
            if (tc) begin
                if (!SATURATE) begin
                    count_d = dir ? LAST : '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = dir ? (count_q - 1'b1) : (count_q + 1'b1);
            end
        end
    end

    // Count and wrap registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_uart_mod_counter.sv
// Directed testbench for uart_mod_counter: a PRESCALE=1 instance and a
// PRESCALE=4 instance share one stimulus bus; each task checks the instance
// relevant to its scenario against hand-computed values.
module tb_uart_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       dir = 1'b0;

    logic [3:0] count_a, count_p;
    logic       tc_a, tc_p, wrap_a, wrap_p;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir),
        .count(count_a), .tc(tc_a), .wrap(wrap_a)
    );

    uart_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut_p (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir),
        .count(count_p), .tc(tc_p), .wrap(wrap_p)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0;
        cyc();
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b0 || tc_a !== 1'b0) $display("FAIL reset_init: count=%0d wrap=%b tc=%b, want 0/0/0", count_a, wrap_a, tc_a);
        else passed++;
        rst = 1'b0; ena = 1'b1;
        repeat (7) cyc();
        checks++;
        if (count_a !== 4'd7) $display("FAIL pre_reset_count: count=%0d, want 7", count_a);
        else passed++;
        checks++;
        if (count_p !== 4'd1) $display("FAIL pre_reset_count_p: count=%0d, want 1", count_p);
        else passed++;
        rst = 1'b1;
        cyc();
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b0 || tc_a !== 1'b0) $display("FAIL reset_mid: count=%0d wrap=%b tc=%b, want 0/0/0", count_a, wrap_a, tc_a);
        else passed++;
        checks++;
        if (count_p !== 4'd0 || wrap_p !== 1'b0) $display("FAIL reset_mid_p: count=%0d wrap=%b, want 0/0", count_p, wrap_p);
        else passed++;
        rst = 1'b0;
        // prescaler phase must be zero after reset: step exactly on the 4th ena
        repeat (3) cyc();
        checks++;
        if (count_p !== 4'd0) $display("FAIL reset_pre_phase3: count=%0d, want 0", count_p);
        else passed++;
        cyc();
        checks++;
        if (count_p !== 4'd1) $display("FAIL reset_pre_phase4: count=%0d, want 1", count_p);
        else passed++;
        ena = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_c;
        clr = 1'b1;
        cyc();
        clr = 1'b0; dir = 1'b0; ena = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            exp_c = 4'(i % 10);
            checks++;
            if (count_a !== exp_c || tc_a !== (exp_c == 4'd9) || wrap_a !== (i == 10))
                $display("FAIL up_step%0d: count=%0d tc=%b wrap=%b, want %0d/%b/%b", i, count_a, tc_a, wrap_a, exp_c, (exp_c == 4'd9), (i == 10));
            else passed++;
        end
        ena = 1'b0;
        cyc();
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b0) $display("FAIL up_idle_hold: count=%0d wrap=%b, want 0/0", count_a, wrap_a);
        else passed++;
    endtask

    task automatic test_down_wrap();
        dir = 1'b1;
        #1;
        checks++;
        if (tc_a !== 1'b1) $display("FAIL down_tc_at0: tc=%b, want 1", tc_a);
        else passed++;
        ena = 1'b1;
        cyc();
        checks++;
        if (count_a !== 4'd9 || wrap_a !== 1'b1 || tc_a !== 1'b0) $display("FAIL down_wrap: count=%0d wrap=%b tc=%b, want 9/1/0", count_a, wrap_a, tc_a);
        else passed++;
        cyc();
        checks++;
        if (count_a !== 4'd8 || wrap_a !== 1'b0) $display("FAIL down_step: count=%0d wrap=%b, want 8/0", count_a, wrap_a);
        else passed++;
        ena = 1'b0;
        load_val = 4'd9; load = 1'b1;
        cyc();
        load = 1'b0;
        checks++;
        if (tc_a !== 1'b0) $display("FAIL tc_dir_down_at9: tc=%b, want 0", tc_a);
        else passed++;
        dir = 1'b0;
        #1;
        checks++;
        if (tc_a !== 1'b1) $display("FAIL tc_dir_follow: tc=%b, want 1", tc_a);
        else passed++;
    endtask

    task automatic test_prescaler();
        logic [8:0] pat;
        logic [3:0] exp_c [9];
        pat = 9'b1_1111_1011; // bit i = ena in cycle i
        exp_c = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
        clr = 1'b1; dir = 1'b0;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ena = pat[i];
            cyc();
            checks++;
            if (count_p !== exp_c[i] || wrap_p !== 1'b0)
                $display("FAIL prescale_clk%0d: count=%0d wrap=%b, want %0d/0", i + 1, count_p, wrap_p, exp_c[i]);
            else passed++;
        end
        ena = 1'b0;
    endtask

    task automatic test_load_clear();
        load = 1'b1; load_val = 4'd12;
        cyc();
        checks++;
        if (count_a !== 4'd9 || tc_a !== 1'b1 || wrap_a !== 1'b0) $display("FAIL load_clamp12: count=%0d tc=%b wrap=%b, want 9/1/0", count_a, tc_a, wrap_a);
        else passed++;
        load_val = 4'd10;
        cyc();
        checks++;
        if (count_a !== 4'd9) $display("FAIL load_clamp10: count=%0d, want 9", count_a);
        else passed++;
        clr = 1'b1; load_val = 4'd5;
        cyc();
        clr = 1'b0;
        checks++;
        if (count_a !== 4'd0) $display("FAIL clr_over_load: count=%0d, want 0", count_a);
        else passed++;
        // load beats a wrapping step on the PRESCALE=1 instance
        load_val = 4'd9;
        cyc();
        load_val = 4'd3; ena = 1'b1;
        cyc();
        checks++;
        if (count_a !== 4'd3 || wrap_a !== 1'b0) $display("FAIL load_over_step: count=%0d wrap=%b, want 3/0", count_a, wrap_a);
        else passed++;
        // prescaled instance: bring prescaler to PRESCALE-1 then load with ena
        load = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (3) cyc();
        load = 1'b1; load_val = 4'd5;
        cyc();
        load = 1'b0;
        checks++;
        if (count_p !== 4'd5 || wrap_p !== 1'b0) $display("FAIL load_at_pre_last: count=%0d wrap=%b, want 5/0", count_p, wrap_p);
        else passed++;
        repeat (3) cyc();
        checks++;
        if (count_p !== 4'd5) $display("FAIL load_pre_restart3: count=%0d, want 5", count_p);
        else passed++;
        cyc();
        checks++;
        if (count_p !== 4'd6) $display("FAIL load_pre_restart4: count=%0d, want 6", count_p);
        else passed++;
        ena = 1'b0;
    endtask

    task automatic test_terminal_mode();
        load = 1'b1; load_val = 4'd9; dir = 1'b0;
        cyc();
        load = 1'b0; ena = 1'b1;
`ifdef UART_CNT_SATURATE_EN
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (count_a !== 4'd9 || wrap_a !== 1'b0 || tc_a !== 1'b1)
                $display("FAIL sat_hold%0d: count=%0d wrap=%b tc=%b, want 9/0/1", i, count_a, wrap_a, tc_a);
            else passed++;
        end
        dir = 1'b1;
        cyc();
        checks++;
        if (count_a !== 4'd8 || wrap_a !== 1'b0) $display("FAIL sat_down: count=%0d wrap=%b, want 8/0", count_a, wrap_a);
        else passed++;
`else
        cyc();
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b1) $display("FAIL wrap_from9: count=%0d wrap=%b, want 0/1", count_a, wrap_a);
        else passed++;
        cyc();
        checks++;
        if (count_a !== 4'd1 || wrap_a !== 1'b0) $display("FAIL after_wrap: count=%0d wrap=%b, want 1/0", count_a, wrap_a);
        else passed++;
`endif
        ena = 1'b0;
    endtask

    task automatic test_back_to_back();
        // clr with ena on the prescaled instance: first step PRESCALE ena cycles later
        clr = 1'b1; ena = 1'b1; dir = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (count_p !== 4'd0 || wrap_p !== 1'b0) $display("FAIL clr_with_ena: count=%0d wrap=%b, want 0/0", count_p, wrap_p);
        else passed++;
        repeat (3) cyc();
        checks++;
        if (count_p !== 4'd0) $display("FAIL clr_pre_restart3: count=%0d, want 0", count_p);
        else passed++;
        cyc();
        checks++;
`ifdef UART_CNT_SATURATE_EN
        if (count_p !== 4'd0 || wrap_p !== 1'b0) $display("FAIL clr_pre_step_down: count=%0d wrap=%b, want 0/0", count_p, wrap_p);
        else passed++;
`else
        if (count_p !== 4'd9 || wrap_p !== 1'b1) $display("FAIL clr_pre_step_down: count=%0d wrap=%b, want 9/1", count_p, wrap_p);
        else passed++;
`endif
        ena = 1'b0; dir = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_prescaler();
        test_load_clear();
        test_terminal_mode();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
